// File: rtl/solution_min_weight_if.sv
// AXI-stream style beat channel carrying candidate solution vectors.
// The master drives data and valid; the slave returns tready.
interface axi_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, tdata, tlast, input tready);
   modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/solution_min_weight.sv
// Consumes one frame of GF(2) solution vectors and reports the minimum-popcount vector.
// Define SOLUTION_MIN_WEIGHT_TOTAL_EN to add the running sum of per-frame minima on `total`.
module solution_min_weight #(
   parameter int NUM_VARS    = 8,
   parameter int COUNT_WIDTH = 16,
   parameter int TOTAL_WIDTH = 16,
   localparam int WW         = $clog2(NUM_VARS + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_stream_if.slave            solution_stream,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [WW-1:0]          min_weight,
   output logic [NUM_VARS-1:0]    min_solution,
   output logic [COUNT_WIDTH-1:0] sol_count
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
   ,
   output logic [TOTAL_WIDTH-1:0] total
`endif
);
   localparam logic [0:0] ACCEPT = 1'b0;
   localparam logic [0:0] HOLD   = 1'b1;

   logic [0:0]          state;
   logic                tready_q;
   logic                have_min;
   logic [NUM_VARS-1:0] vec;
   logic [WW-1:0]       w;
   logic                beat;
   logic                take;

   assign vec                    = solution_stream.tdata[NUM_VARS-1:0];
   assign solution_stream.tready = tready_q;
   assign result_valid           = (state == HOLD);
   assign beat                   = solution_stream.tvalid && tready_q;
   // Strict compare: on a tie the earlier vector of the frame is kept.
   assign take                   = !have_min || (w < min_weight);

   always_comb begin
      w = '0;
      for (int i = 0; i < NUM_VARS; i++)
         w = w + WW'(vec[i]);
   end

   generate
      if (NUM_VARS < 8) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^solution_stream.tdata[7:NUM_VARS];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ACCEPT;
         tready_q     <= 1'b0;
         have_min     <= 1'b0;
         min_weight   <= '0;
         min_solution <= '0;
         sol_count    <= '0;
      end else begin
         case (state)
            ACCEPT: begin
               tready_q <= 1'b1;
               if (beat) begin
                  if (take) begin
                     min_weight   <= w;
                     min_solution <= vec;
                  end
                  have_min <= 1'b1;
                  if (sol_count != '1)
                     sol_count <= sol_count + COUNT_WIDTH'(1);
                  if (solution_stream.tlast) begin
                     state    <= HOLD;
                     tready_q <= 1'b0;
                  end
               end
            end
            HOLD: begin
               // Min registers are left as-is; the next frame's first beat overwrites them.
               if (result_ready) begin
                  state     <= ACCEPT;
                  tready_q  <= 1'b1;
                  have_min  <= 1'b0;
                  sol_count <= '0;
               end
            end
            default: begin
               state    <= ACCEPT;
               tready_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
   // Adds the frame's final minimum, which includes the tlast beat itself.
   always_ff @(posedge clk) begin
      if (!rst_n)
         total <= '0;
      else if (beat && solution_stream.tlast)
         total <= total + TOTAL_WIDTH'(take ? w : min_weight);
   end
`endif
endmodule

// File: tb/tb_solution_min_weight.sv
// Directed bench for solution_min_weight: an 8-variable and a 4-variable instance.
// Checks on `total` are compiled only when SOLUTION_MIN_WEIGHT_TOTAL_EN is defined.
module tb_solution_min_weight;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   axi_stream_if #(.DATA_WIDTH(8)) s8 ();
   axi_stream_if #(.DATA_WIDTH(8)) s4 ();

   logic        rv8, rr8, rv4, rr4;
   logic [3:0]  mw8;
   logic [7:0]  ms8;
   logic [15:0] sc8;
   logic [2:0]  mw4;
   logic [3:0]  ms4;
   logic [15:0] sc4;
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
   logic [15:0] tot8, tot4;
`endif

   solution_min_weight #(.NUM_VARS(8)) u8 (
      .clk(clk), .rst_n(rst_n), .solution_stream(s8.slave),
      .result_valid(rv8), .result_ready(rr8),
      .min_weight(mw8), .min_solution(ms8), .sol_count(sc8)
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
      , .total(tot8)
`endif
   );

   solution_min_weight #(.NUM_VARS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .solution_stream(s4.slave),
      .result_valid(rv4), .result_ready(rr4),
      .min_weight(mw4), .min_solution(ms4), .sol_count(sc4)
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
      , .total(tot4)
`endif
   );

   // Presents one beat to the 8-var instance; returns right after the accepting edge.
   task automatic send8(input logic [7:0] d, input logic last);
      int n;
      @(negedge clk);
      s8.tvalid = 1'b1; s8.tdata = d; s8.tlast = last;
      n = 0;
      while (!s8.tready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL send8_timeout: tready=%0b required 1", s8.tready);
      end
      @(posedge clk);
   endtask

   task automatic send4(input logic [7:0] d, input logic last);
      int n;
      @(negedge clk);
      s4.tvalid = 1'b1; s4.tdata = d; s4.tlast = last;
      n = 0;
      while (!s4.tready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL send4_timeout: tready=%0b required 1", s4.tready);
      end
      @(posedge clk);
   endtask

   // Called right after a tlast beat's edge: checks the HOLD-cycle outputs.
   task automatic check_result8(input string nm, input logic [3:0] ew, input logic [7:0] es,
                                input logic [15:0] ec);
      @(negedge clk);
      s8.tvalid = 1'b0; s8.tlast = 1'b0;
      n_checks++; if (rv8 !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %0b exp 1", nm, rv8); end
      n_checks++; if (s8.tready !== 1'b0) begin n_fail++; $display("FAIL %s_tready: got %0b exp 0", nm, s8.tready); end
      n_checks++; if (mw8 !== ew) begin n_fail++; $display("FAIL %s_weight: got %0d exp %0d", nm, mw8, ew); end
      n_checks++; if (ms8 !== es) begin n_fail++; $display("FAIL %s_solution: got %0h exp %0h", nm, ms8, es); end
      n_checks++; if (sc8 !== ec) begin n_fail++; $display("FAIL %s_count: got %0d exp %0d", nm, sc8, ec); end
   endtask

   task automatic test_reset;
      s8.tvalid = 1'b0; s8.tdata = '0; s8.tlast = 1'b0;
      s4.tvalid = 1'b0; s4.tdata = '0; s4.tlast = 1'b0;
      rr8 = 1'b1; rr4 = 1'b1; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (s8.tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %0b exp 0", s8.tready); end
      n_checks++; if (rv8 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b exp 0", rv8); end
      n_checks++; if (mw8 !== 4'd0) begin n_fail++; $display("FAIL rst_weight: got %0d exp 0", mw8); end
      n_checks++; if (ms8 !== 8'h00) begin n_fail++; $display("FAIL rst_solution: got %0h exp 0", ms8); end
      n_checks++; if (sc8 !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", sc8); end
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
      n_checks++; if (tot8 !== 16'd0) begin n_fail++; $display("FAIL rst_total: got %0d exp 0", tot8); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (s8.tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready_rise: got %0b exp 1", s8.tready); end
   endtask

   task automatic test_basic_tie;
      send8(8'h07, 1'b0);
      send8(8'h03, 1'b0);
      send8(8'h05, 1'b1);
      check_result8("basic", 4'd2, 8'h03, 16'd3);
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
      n_checks++; if (tot8 !== 16'd2) begin n_fail++; $display("FAIL basic_total: got %0d exp 2", tot8); end
`endif
      // HOLD lasts one cycle with result_ready high; count clears, min retained.
      @(negedge clk);
      n_checks++; if (rv8 !== 1'b0) begin n_fail++; $display("FAIL basic_release: got %0b exp 0", rv8); end
      n_checks++; if (sc8 !== 16'd0) begin n_fail++; $display("FAIL basic_count_clr: got %0d exp 0", sc8); end
      n_checks++; if (mw8 !== 4'd2) begin n_fail++; $display("FAIL basic_weight_kept: got %0d exp 2", mw8); end
      n_checks++; if (s8.tready !== 1'b1) begin n_fail++; $display("FAIL basic_tready_back: got %0b exp 1", s8.tready); end
   endtask

   task automatic test_zero_frame;
      send8(8'h00, 1'b1);
      check_result8("zero", 4'd0, 8'h00, 16'd1);
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
      n_checks++; if (tot8 !== 16'd2) begin n_fail++; $display("FAIL zero_total: got %0d exp 2", tot8); end
`endif
   endtask

   task automatic test_total;
      send8(8'h07, 1'b0);
      send8(8'h0E, 1'b1);
      check_result8("third", 4'd3, 8'h07, 16'd2);
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
      n_checks++; if (tot8 !== 16'd5) begin n_fail++; $display("FAIL third_total: got %0d exp 5", tot8); end
`endif
   endtask

   task automatic test_stall_gaps;
      send8(8'h06, 1'b0);
      repeat (3) begin @(negedge clk); s8.tvalid = 1'b0; end
      send8(8'h01, 1'b1);
      check_result8("stall", 4'd1, 8'h01, 16'd2);
   endtask

   task automatic test_backpressure;
      rr4 = 1'b0;
      send4(8'hF1, 1'b0);
      send4(8'h2E, 1'b1);
      @(negedge clk);
      s4.tvalid = 1'b1; s4.tdata = 8'h00; s4.tlast = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (s4.tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready[%0d]: got %0b exp 0", i, s4.tready); end
         n_checks++; if (rv4 !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b exp 1", i, rv4); end
         n_checks++; if (mw4 !== 3'd1) begin n_fail++; $display("FAIL bp_weight[%0d]: got %0d exp 1", i, mw4); end
         n_checks++; if (ms4 !== 4'h1) begin n_fail++; $display("FAIL bp_solution[%0d]: got %0h exp 1", i, ms4); end
         n_checks++; if (sc4 !== 16'd2) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d exp 2", i, sc4); end
         if (i < 4) @(negedge clk);
      end
      // The offered beat must not be taken in the HOLD-exit cycle.
      rr4 = 1'b1;
      @(negedge clk);
      n_checks++; if (s4.tready !== 1'b1) begin n_fail++; $display("FAIL bp_tready_rise: got %0b exp 1", s4.tready); end
      n_checks++; if (sc4 !== 16'd0) begin n_fail++; $display("FAIL bp_not_consumed: got %0d exp 0", sc4); end
      @(negedge clk);
      s4.tvalid = 1'b0; s4.tlast = 1'b0;
      n_checks++; if (rv4 !== 1'b1) begin n_fail++; $display("FAIL bp_next_frame: got %0b exp 1", rv4); end
      n_checks++; if (sc4 !== 16'd1) begin n_fail++; $display("FAIL bp_next_count: got %0d exp 1", sc4); end
      n_checks++; if (mw4 !== 3'd0) begin n_fail++; $display("FAIL bp_next_weight: got %0d exp 0", mw4); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame;
      send8(8'h01, 1'b0);
      send8(8'h03, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      s8.tvalid = 1'b1; s8.tdata = 8'hFF; s8.tlast = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      s8.tvalid = 1'b0; s8.tlast = 1'b0;
      n_checks++; if (sc8 !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d exp 0", sc8); end
      send8(8'h0F, 1'b1);
      check_result8("mid_rst", 4'd4, 8'h0F, 16'd1);
`ifdef SOLUTION_MIN_WEIGHT_TOTAL_EN
      n_checks++; if (tot8 !== 16'd4) begin n_fail++; $display("FAIL mid_rst_total: got %0d exp 4", tot8); end
`endif
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic_tie();
      test_zero_frame();
      test_total();
      test_stall_gaps();
      test_backpressure();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: time=%0t limit=100000", $time);
      $fatal(1);
   end
endmodule

// File: doc/solution_min_weight.md
# solution_min_weight

Receiving end of the `enumerate_solutions` solution stream. The block consumes one frame of candidate GF(2) solution vectors, where each beat is one button-press vector and `tlast` marks the last beat. It reports the minimum-popcount vector of that frame, which is the fewest presses for that machine. It sits directly downstream of `enumerate_solutions` and upstream of the puzzle-answer logic. With the total feature compiled in, it also keeps the running sum of per-frame minima.

## Interface

Parameters:
- `NUM_VARS`, 8: number of free variables. Only `tdata[NUM_VARS-1:0]` is evaluated, and `NUM_VARS` ≤ 8.
- `COUNT_WIDTH`, 16: width of the per-frame beat counter.
- `TOTAL_WIDTH`, 16: width of the running-total accumulator.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `solution_stream`  sink  `axi_stream_if` with `DATA_WIDTH` = 8.
  - `tvalid`, `tdata`, `tlast` are inputs.
  - `tready` is driven by this block.
- `result_valid`  out  1  — frame result available.
- `result_ready`  in  1  — downstream accepts the result.
- `min_weight`  out  $clog2(NUM_VARS+1)  — popcount of the best vector.
- `min_solution`  out  NUM_VARS  — best vector.
- `sol_count`  out  COUNT_WIDTH  — beats in the frame, saturating.
- `total`  out  TOTAL_WIDTH  — sum of accepted `min_weight` values. Present only with `SOLUTION_MIN_WEIGHT_TOTAL_EN`.

## Operation

- FSM states:
  - `ACCEPT`: `tready`=1, `result_valid`=0.
  - `HOLD`: `tready`=0, `result_valid`=1.
- A beat is accepted when `tvalid && tready`.
  - Compute `w = popcount(tdata[NUM_VARS-1:0])`; bits above `NUM_VARS` are ignored.
  - If no beat has been accepted yet in this frame (internal `have_min` flag is 0), or `w < min_weight`, load `min_weight` with `w` and `min_solution` with the masked `tdata`, and set `have_min`.
  - Ties keep the earlier vector, because the comparison is strict.
  - `sol_count` increments and saturates at all-ones.
- Accepted beat with `tlast`=1:
  - Performs the update above in the same cycle.
  - Next state is `HOLD`.
  - With the macro, `total <= total + final min_weight`, where the final value includes this last beat. `total` wraps modulo 2^TOTAL_WIDTH.
- `HOLD` to `ACCEPT` transition, on `result_valid && result_ready`:
  - Clear `have_min` and `sol_count`.
  - `min_weight` and `min_solution` keep their values until the first beat of the next frame overwrites them.
  - `total` is retained.
- In `HOLD`, the outputs `min_weight`, `min_solution`, `sol_count` and `total` are stable.
- Frames are never empty; a one-beat frame has `tlast` on its only beat.

## Timing

- Reset values, while `rst_n`=0 at a clock edge:
  - state `ACCEPT`, but `tready`=0 while `rst_n` is low;
  - `result_valid`=0;
  - `min_weight`, `min_solution`, `sol_count`, `total` all 0;
  - `have_min`=0.
- `tready` rises in the first cycle after `rst_n` is sampled high.
- `tready` is a registered function of state, with no combinational path from `tvalid`.
- Latency: `result_valid` asserts exactly 1 cycle after the `tlast` beat is accepted.
- Throughput: one beat per cycle in `ACCEPT`. There is a minimum 1-cycle bubble per frame (`HOLD`), and more while `result_ready` is low.
- Simultaneous events: a `tvalid` beat presented in the cycle that `HOLD` exits is not accepted, since `tready` is still 0. It is accepted in the following cycle.
- Reset mid-frame or mid-`HOLD` discards the partial frame and clears `total`. The upstream beat offered in the reset cycle is not consumed.
- `tvalid` gaps inside a frame have no effect on the result.

## Configuration

- `SOLUTION_MIN_WEIGHT_TOTAL_EN` defined:
  - the `total` port and its accumulator exist;
  - `total` updates once per frame, as described in Operation.
- Macro not defined:
  - the `total` port and register are absent;
  - all other behaviour and timing are identical.

## Test plan

- **Basic frame with tie.** Beats 0x07, 0x03, 0x05 (`tlast` on 0x05), `result_ready`=1.
  - Expect `result_valid` 1 cycle after 0x05.
  - Expect `min_weight`=2, `min_solution`=0x03 (tie, first wins), `sol_count`=3.
- **Single-beat zero frame.** Beat 0x00 with `tlast`.
  - Expect `min_weight`=0, `min_solution`=0x00, `sol_count`=1.
- **Backpressure and masking.** `NUM_VARS`=4; beats 0xF1, 0x2E (`tlast`); `result_ready` held low for 5 cycles.
  - Expect `min_weight`=1 from 0x1, since the upper bits are masked.
  - Expect `tready`=0 and the outputs stable for 5 cycles.
  - Expect `tready`=1 one cycle after `result_ready` rises.
- **Running total (macro on).** Three frames with minima 2, 0, 3.
  - Expect `total`=2, 2, 5 after each frame.
  - Macro off: the design elaborates without the `total` port.
- **Reset mid-frame.** Send 0x01 and 0x03 without `tlast`, pulse `rst_n` low for 1 cycle, then send 0x0F with `tlast`.
  - Expect `min_weight`=4, `sol_count`=1, `total`=4.
- **Stall gaps.** Frame 0x06, 0x01 (`tlast`) with `tvalid` low for 3 cycles between the beats.
  - Expect `min_weight`=1, `min_solution`=0x01.
